// File: rtl/mop_load_sequencer_if.sv
// -----------------------------------------------------------------------------
// REG_BUS
// Simple single-cycle register bus shared by the debug MOP blocks.
//
// Signals
//   addr   : byte address from the requester
//   write  : 1 = write access, 0 = read access
//   wdata  : write data
//   wstrb  : byte write strobes
//   valid  : an access is presented this cycle
//   rdata  : read data returned by the device (combinational)
//   ready  : the device accepts the access this cycle
//   error  : the access was rejected
//
// Modports
//   in  : device side (register file)
//   out : requester side
// -----------------------------------------------------------------------------
interface REG_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    ready;
    logic                    error;

    modport in (
        input  addr, write, wdata, wstrb, valid,
        output rdata, ready, error
    );

    modport out (
        output addr, write, wdata, wstrb, valid,
        input  rdata, ready, error
    );
endinterface

// File: rtl/mop_load_sequencer.sv
// -----------------------------------------------------------------------------
// mop_load_sequencer
// Multi-target MOP loader. Software programs a target index and a word count,
// pushes instruction words into a small FIFO and issues START. The sequencer
// then streams the words to the selected peripheral, one strobe/ack handshake
// per word, with an ack timeout, abort, sticky status and register locking.
// It also holds the redirect-override configuration consumed by redirect_mop.
//
// Ports
//   clk_i           : clock
//   rst_ni          : synchronous active-low reset
//   reglk_ctrl_i    : bit0 locks TARGET/COUNT/OVR writes, bit1 locks CMD start
//   external_bus_io : register bus (device side), always ready
//   load_ctrl       : one-hot load strobe, held until the target acks
//   instrut_value   : instruction word presented with the strobe
//   load_ack_i      : per-target word accept
//   done_o          : one-cycle pulse when a load command completes
//   override_o      : redirect override enable
//   r_source_o      : redirect source index
//   r_target_o      : redirect target index
//
// Register map (word index = addr[8:2])
//   0 CMD    W  bit0 start, bit1 abort, bit2 clear status
//   1 TARGET RW target index
//   2 COUNT  RW words per command (4 bits)
//   3 DATA   W  push wdata[INSTR_WIDTH-1:0] into the FIFO
//   4 STATUS R  {done[8], fifo_level[7:4], ovf[3], timeout[2], bad_cfg[1], busy[0]}
//   5 OVR    RW bit0 override, [8+:LOG] source, [16+:LOG] target
// Byte strobes are ignored; every write updates the whole register.
// -----------------------------------------------------------------------------
module mop_load_sequencer #(
    parameter int N_TARGETS     = 16,
    parameter int LOG_N_TARGETS = $clog2(N_TARGETS),
    parameter int INSTR_WIDTH   = 8,
    parameter int MAX_WORDS     = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               reglk_ctrl_i,
    REG_BUS.in                       external_bus_io,
    output logic [N_TARGETS-1:0]     load_ctrl,
    output logic [INSTR_WIDTH-1:0]   instrut_value,
    input  logic [N_TARGETS-1:0]     load_ack_i,
    output logic                     done_o,
    output logic                     override_o,
    output logic [LOG_N_TARGETS-1:0] r_source_o,
    output logic [LOG_N_TARGETS-1:0] r_target_o
);

    // TARGET is kept wider than the index so out-of-range values (e.g. 16)
    // survive to the start-time check and are reported as bad_cfg.
    localparam int TGT_W = (LOG_N_TARGETS < 8) ? 8 : LOG_N_TARGETS + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [6:0] REG_CMD    = 7'd0;
    localparam logic [6:0] REG_TARGET = 7'd1;
    localparam logic [6:0] REG_COUNT  = 7'd2;
    localparam logic [6:0] REG_DATA   = 7'd3;
    localparam logic [6:0] REG_STATUS = 7'd4;
    localparam logic [6:0] REG_OVR    = 7'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [3:0]               sent_q, sent_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     fetched_q, fetched_d;   // word_q holds a popped word
    logic [N_TARGETS-1:0]     load_ctrl_q, load_ctrl_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;

    logic [TGT_W-1:0]         target_q;
    logic [3:0]               count_q;
    logic                     ovr_en_q;
    logic [LOG_N_TARGETS-1:0] ovr_src_q;
    logic [LOG_N_TARGETS-1:0] ovr_tgt_q;
    logic                     done_q;
    logic                     ovf_q;
    logic                     timeout_q;
    logic                     bad_cfg_q;
    logic [INSTR_WIDTH-1:0]   word_q;

    logic [INSTR_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [LVL_W-1:0]         level_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [6:0]  idx;
    logic [31:0] wdata;
    logic        bus_wr;
    logic        mapped;
    logic        sel_cmd, sel_target, sel_count, sel_data, sel_ovr;
    logic        busy;
    logic        wr_err;
    logic        wr_ok;
    logic        cmd_start, cmd_abort, cmd_clear;
    logic        push_req;
    logic [31:0] status_w;
    logic [31:0] rdata;

    assign idx    = external_bus_io.addr[8:2];
    assign wdata  = external_bus_io.wdata;
    assign bus_wr = external_bus_io.valid & external_bus_io.write;
    assign mapped = (idx <= REG_OVR);

    assign sel_cmd    = (idx == REG_CMD);
    assign sel_target = (idx == REG_TARGET);
    assign sel_count  = (idx == REG_COUNT);
    assign sel_data   = (idx == REG_DATA);
    assign sel_ovr    = (idx == REG_OVR);

    assign busy = (state_q == S_LOAD) || (state_q == S_WAIT_ACK) || (state_q == S_DONE);

    // Rejected writes: locked config, locked start, or reprogramming the
    // active target/count in the middle of a command.
    assign wr_err = bus_wr & (
                        (reglk_ctrl_i[0] & (sel_target | sel_count | sel_ovr)) |
                        (reglk_ctrl_i[1] & sel_cmd & wdata[0]) |
                        (busy & (sel_target | sel_count)));

    assign wr_ok     = bus_wr & mapped & ~wr_err;
    assign cmd_start = wr_ok & sel_cmd & wdata[0];
    assign cmd_abort = wr_ok & sel_cmd & wdata[1];
    assign cmd_clear = wr_ok & sel_cmd & wdata[2];
    assign push_req  = wr_ok & sel_data;

    assign external_bus_io.ready = 1'b1;
    assign external_bus_io.error = external_bus_io.valid & (~mapped | wr_err);
    assign external_bus_io.rdata = rdata;

    always_comb begin
        status_w      = '0;
        status_w[0]   = busy;
        status_w[1]   = bad_cfg_q;
        status_w[2]   = timeout_q;
        status_w[3]   = ovf_q;
        status_w[7:4] = 4'(level_q);
        status_w[8]   = done_q;
    end

    always_comb begin
        rdata = '0;
        case (idx)
            REG_TARGET: rdata[TGT_W-1:0] = target_q;
            REG_COUNT:  rdata[3:0]       = count_q;
            REG_STATUS: rdata            = status_w;
            REG_OVR: begin
                rdata[0]                 = ovr_en_q;
                rdata[8 +: LOG_N_TARGETS]  = ovr_src_q;
                rdata[16 +: LOG_N_TARGETS] = ovr_tgt_q;
            end
            default: rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO status and target decode
    // ------------------------------------------------------------------
    logic                     fifo_empty, fifo_full;
    logic                     fifo_pop, fifo_flush, fifo_push;
    logic [LOG_N_TARGETS-1:0] tgt_idx;
    logic [N_TARGETS-1:0]     tgt_onehot;
    logic                     ack_hit;
    logic                     cfg_ok;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push in the same cycle a word leaves it.
    assign fifo_push  = push_req & (~fifo_full | fifo_pop);

    assign tgt_idx = target_q[LOG_N_TARGETS-1:0];
    assign ack_hit = load_ack_i[tgt_idx];
    assign cfg_ok  = (int'(target_q) < N_TARGETS) && (count_q != 4'd0) &&
                     (int'(count_q) <= MAX_WORDS);

    always_comb begin
        tgt_onehot          = '0;
        tgt_onehot[tgt_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic set_bad, set_timeout, clr_done;

    // NOTE: every signal gets its default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        sent_d      = sent_q;
        timer_d     = timer_q;
        fetched_d   = fetched_q;
        load_ctrl_d = load_ctrl_q;
        instr_d     = instr_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        set_bad     = 1'b0;
        set_timeout = 1'b0;
        clr_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cfg_ok) begin
                        sent_d    = '0;
                        fetched_d = 1'b0;
                        clr_done  = 1'b1;
                        state_d   = S_LOAD;
                    end else begin
                        set_bad = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end

            // Two phases: pop a word into word_q, then launch it on the next
            // edge. Together with at least one WAIT_ACK cycle this gives the
            // three-cycle minimum per word.
            S_LOAD: begin
                if (fetched_q) begin
                    load_ctrl_d = tgt_onehot;
                    instr_d     = word_q;
                    timer_d     = '0;
                    fetched_d   = 1'b0;
                    state_d     = S_WAIT_ACK;
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    fetched_d = 1'b1;
                end
            end

            S_WAIT_ACK: begin
                if (ack_hit) begin
                    load_ctrl_d = '0;
                    sent_d      = sent_q + 4'd1;
                    state_d     = ((sent_q + 4'd1) == count_q) ? S_DONE : S_LOAD;
                end else if (timer_q == TMR_LAST) begin
                    set_timeout = 1'b1;
                    load_ctrl_d = '0;
                    state_d     = S_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_DONE: state_d = S_IDLE;

            S_ERROR: begin
                load_ctrl_d = '0;
                if (cmd_clear) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the state logic decided, including a start
        // carried in the same write.
        if (cmd_abort) begin
            state_d     = S_IDLE;
            load_ctrl_d = '0;
            sent_d      = '0;
            fetched_d   = 1'b0;
            fifo_pop    = 1'b0;
            fifo_flush  = 1'b1;
            set_bad     = 1'b0;
            set_timeout = 1'b0;
            clr_done    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sent_q      <= '0;
            timer_q     <= '0;
            fetched_q   <= 1'b0;
            load_ctrl_q <= '0;
            instr_q     <= '0;
        end else begin
            sent_q      <= sent_d;
            timer_q     <= timer_d;
            fetched_q   <= fetched_d;
            load_ctrl_q <= load_ctrl_d;
            instr_q     <= instr_d;
        end
    end

    // ------------------------------------------------------------------
    // Configuration and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            target_q  <= '0;
            count_q   <= '0;
            ovr_en_q  <= 1'b0;
            ovr_src_q <= '0;
            ovr_tgt_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            bad_cfg_q <= 1'b0;
        end else begin
            if (wr_ok && sel_target) target_q <= wdata[TGT_W-1:0];
            if (wr_ok && sel_count)  count_q  <= wdata[3:0];
            if (wr_ok && sel_ovr) begin
                ovr_en_q  <= wdata[0];
                ovr_src_q <= wdata[8 +: LOG_N_TARGETS];
                ovr_tgt_q <= wdata[16 +: LOG_N_TARGETS];
            end

            if (clr_done)               done_q <= 1'b0;
            else if (state_q == S_DONE) done_q <= 1'b1;

            // A new event in the same cycle as a clear wins, so it is not lost.
            if (cmd_clear) begin
                ovf_q     <= 1'b0;
                timeout_q <= 1'b0;
                bad_cfg_q <= 1'b0;
            end
            if (push_req && !fifo_push) ovf_q     <= 1'b1;
            if (set_timeout)            timeout_q <= 1'b1;
            if (set_bad)                bad_cfg_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            word_q   <= '0;
        end else if (fifo_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                word_q   <= fifo_mem_q[rd_ptr_q];
            end
            case ({fifo_push, fifo_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; level_q gates every read, so stale
    // contents are never observed and the array can map onto plain flops/RAM.
    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q] <= wdata[INSTR_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_ctrl     = load_ctrl_q;
    assign instrut_value = instr_q;
    assign done_o        = (state_q == S_DONE);
    assign override_o    = ovr_en_q;
    assign r_source_o    = ovr_src_q;
    assign r_target_o    = ovr_tgt_q;

    // Address bits outside the decode window, strobes and spare lock bits.
    logic unused_bus;
    assign unused_bus = ^{external_bus_io.addr, external_bus_io.wstrb, wdata,
                          reglk_ctrl_i[7:2]};

endmodule

// File: tb/tb_mop_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mop_load_sequencer
// Directed bench for mop_load_sequencer: register access, normal loads, FIFO
// stall and overflow, ack timeout, config errors, locking, abort and reset.
// Expected values are worked out by hand from the register map and the
// LOAD -> WAIT_ACK handshake timing.
// -----------------------------------------------------------------------------
module tb_mop_load_sequencer;

    localparam logic [6:0] R_CMD    = 7'd0;
    localparam logic [6:0] R_TARGET = 7'd1;
    localparam logic [6:0] R_COUNT  = 7'd2;
    localparam logic [6:0] R_DATA   = 7'd3;
    localparam logic [6:0] R_STATUS = 7'd4;
    localparam logic [6:0] R_OVR    = 7'd5;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [7:0]  reglk;
    logic [15:0] load_ctrl;
    logic [7:0]  instr;
    logic [15:0] load_ack;
    logic        done;
    logic        ovr;
    logic [3:0]  rsrc;
    logic [3:0]  rtgt;

    int n_checks = 0;
    int n_fail   = 0;

    REG_BUS bus ();

    mop_load_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .reglk_ctrl_i    (reglk),
        .external_bus_io (bus),
        .load_ctrl       (load_ctrl),
        .instrut_value   (instr),
        .load_ack_i      (load_ack),
        .done_o          (done),
        .override_o      (ovr),
        .r_source_o      (rsrc),
        .r_target_o      (rtgt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive on the falling edge, sample the combinational response just after,
    // let the DUT capture on the rising edge.
    task automatic bus_write(input logic [6:0] idx, input logic [31:0] data, output logic err);
        @(negedge clk);
        bus.addr  = {23'd0, idx, 2'b00};
        bus.wdata = data;
        bus.wstrb = 4'hF;
        bus.write = 1'b1;
        bus.valid = 1'b1;
        #1 err = bus.error;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] idx, output logic [31:0] data, output logic err);
        @(negedge clk);
        bus.addr  = {23'd0, idx, 2'b00};
        bus.write = 1'b0;
        bus.valid = 1'b1;
        #1;
        data = bus.rdata;
        err  = bus.error;
        @(posedge clk);
        #1 bus.valid = 1'b0;
    endtask

    task automatic wr(input logic [6:0] idx, input logic [31:0] data);
        logic e;
        bus_write(idx, data, e);
        check("wr_no_err", {31'd0, e}, 32'd0);
    endtask

    task automatic rd_status(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        bus_read(R_STATUS, d, e);
        check(tag, d, exp);
    endtask

    // Bounded wait for the strobe, sampled on falling edges.
    task automatic wait_strobe(output int n);
        n = 0;
        while (load_ctrl == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Check strobe and data, present acks on the other targets for 'delay'
    // cycles (the strobe must hold), then ack and check the strobe drops.
    task automatic serve_word(input string tag, input int tgt, input logic [7:0] val,
                              input int delay, output int gap);
        logic [15:0] exp;
        exp      = '0;
        exp[tgt] = 1'b1;
        wait_strobe(gap);
        check({tag, "_strobe"}, 32'(load_ctrl), 32'(exp));
        check({tag, "_data"}, 32'(instr), 32'(val));
        repeat (delay) begin
            load_ack = ~exp;
            @(negedge clk);
        end
        check({tag, "_hold"}, 32'(load_ctrl), 32'(exp));
        load_ack = exp;
        @(negedge clk);
        load_ack = '0;
        check({tag, "_drop"}, 32'(load_ctrl), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          gap;

        rst_ni    = 1'b0;
        reglk     = '0;
        load_ack  = '0;
        bus.valid = 1'b0;
        bus.write = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_load_ctrl", 32'(load_ctrl), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovr", {31'd0, ovr}, 32'd0);
        rst_ni = 1'b1;
        rd_status("rst_status", 32'h0);

        // Redirect override registers
        wr(R_OVR, 32'h0000_0501);
        check("ovr_en", {31'd0, ovr}, 32'd1);
        check("ovr_src", 32'(rsrc), 32'd5);
        check("ovr_tgt", 32'(rtgt), 32'd0);
        bus_read(R_OVR, d, e);
        check("ovr_rdback", d, 32'h501);

        // Two-word load to target 3
        wr(R_TARGET, 32'd3);
        wr(R_COUNT, 32'd2);
        wr(R_DATA, 32'hA1);
        wr(R_DATA, 32'hB2);
        wr(R_CMD, 32'h1);
        serve_word("w0", 3, 8'hA1, 1, gap);
        serve_word("w1", 3, 8'hB2, 1, gap);
        check("w1_gap", 32'(gap), 32'd2);
        check("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        rd_status("status_done", 32'h100);

        // Stall in LOAD until more words arrive
        wr(R_COUNT, 32'd3);
        wr(R_DATA, 32'h11);
        wr(R_CMD, 32'h1);
        serve_word("s0", 3, 8'h11, 0, gap);
        repeat (10) @(negedge clk);
        check("stall_strobe", 32'(load_ctrl), 32'd0);
        rd_status("stall_status", 32'h001);
        wr(R_DATA, 32'h22);
        wr(R_DATA, 32'h33);
        serve_word("s1", 3, 8'h22, 0, gap);
        serve_word("s2", 3, 8'h33, 2, gap);
        check("stall_done", {31'd0, done}, 32'd1);

        // Overflow: five pushes into four entries
        for (int i = 0; i < 5; i++) wr(R_DATA, 32'hC0 + 32'(i));
        rd_status("ovf_status", 32'h148);

        // Ack timeout: strobe held exactly TIMEOUT cycles
        wr(R_COUNT, 32'd1);
        wr(R_CMD, 32'h1);
        wait_strobe(gap);
        check("to_strobe", 32'(load_ctrl), 32'h8);
        check("to_data", 32'(instr), 32'hC0);
        repeat (254) @(negedge clk);
        check("to_hold_254", 32'(load_ctrl), 32'h8);
        @(negedge clk);
        check("to_drop_255", 32'(load_ctrl), 32'd0);
        rd_status("to_status", 32'h3C);
        wr(R_CMD, 32'h4);
        rd_status("to_cleared", 32'h30);

        // Invalid configuration
        wr(R_COUNT, 32'd0);
        wr(R_CMD, 32'h1);
        repeat (5) @(negedge clk);
        check("cnt0_no_strobe", 32'(load_ctrl), 32'd0);
        rd_status("cnt0_status", 32'h32);
        wr(R_CMD, 32'h4);
        wr(R_TARGET, 32'd16);
        wr(R_COUNT, 32'd1);
        wr(R_CMD, 32'h1);
        repeat (5) @(negedge clk);
        check("tgt16_no_strobe", 32'(load_ctrl), 32'd0);
        rd_status("tgt16_status", 32'h32);
        wr(R_CMD, 32'h4);
        wr(R_TARGET, 32'd3);

        // Register locks and unmapped access
        reglk = 8'h01;
        bus_write(R_TARGET, 32'd5, e);
        check("lock_err", {31'd0, e}, 32'd1);
        reglk = 8'h00;
        bus_read(R_TARGET, d, e);
        check("lock_keep", d, 32'd3);
        reglk = 8'h02;
        bus_write(R_CMD, 32'h1, e);
        check("lock_cmd_err", {31'd0, e}, 32'd1);
        reglk = 8'h00;
        rd_status("lock_cmd_idle", 32'h30);
        bus_read(7'd6, d, e);
        check("unmapped_err", {31'd0, e}, 32'd1);

        // Abort while waiting for an ack
        wr(R_COUNT, 32'd2);
        wr(R_CMD, 32'h1);
        wait_strobe(gap);
        check("ab_strobe", 32'(load_ctrl), 32'h8);
        check("ab_data", 32'(instr), 32'hC1);
        bus_write(R_TARGET, 32'd5, e);
        check("busy_wr_err", {31'd0, e}, 32'd1);
        bus_write(R_CMD, 32'h2, e);
        check("ab_drop", 32'(load_ctrl), 32'd0);
        rd_status("ab_status", 32'h000);
        bus_read(R_TARGET, d, e);
        check("busy_wr_keep", d, 32'd3);

        // Reset in the middle of a load
        wr(R_DATA, 32'hD1);
        wr(R_COUNT, 32'd1);
        wr(R_CMD, 32'h1);
        wait_strobe(gap);
        check("mr_data", 32'(instr), 32'hD1);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        check("mr_load_ctrl", 32'(load_ctrl), 32'd0);
        check("mr_instr", 32'(instr), 32'd0);
        check("mr_ovr", {31'd0, ovr}, 32'd0);
        check("mr_src", 32'(rsrc), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        rd_status("mr_status", 32'h0);
        bus_read(R_OVR, d, e);
        check("mr_ovr_reg", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mop_load_sequencer.md
Name: mop_load_sequencer

Overview:
- Parametrised successor to the single-channel debug MOP loader.
- Accepts a target index, a word count and instruction words over the register bus, and buffers the words in a FIFO.
- Streams the words to one of N_TARGETS peripherals with a per-word strobe/ack handshake, plus a timeout, status/abort and register-lock gating.
- Also exports the redirect-override configuration for the redirect_mop block.

Parameters:
- N_TARGETS, 16, number of loadable peripherals; load_ctrl width.
- LOG_N_TARGETS, $clog2(N_TARGETS), target index width.
- INSTR_WIDTH, 8, width of instrut_value.
- MAX_WORDS, 8, maximum words per load command.
- FIFO_DEPTH, 4, instruction FIFO depth (power of 2).
- TIMEOUT, 255, max cycles waiting for an ack before error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- reglk_ctrl_i  in  8  register lock; bit0 locks TARGET/COUNT/OVR, bit1 locks CMD start
- external_bus_io  REG_BUS.in  -  addr/write/wdata/wstrb/valid in; rdata/ready/error out
- load_ctrl  out  N_TARGETS  one-hot load strobe
- instrut_value  out  INSTR_WIDTH  word being loaded
- load_ack_i  in  N_TARGETS  per-target word accept
- done_o  out  1  one-cycle pulse at load completion
- override_o  out  1  redirect override enable
- r_source_o  out  LOG_N_TARGETS  redirect source
- r_target_o  out  LOG_N_TARGETS  redirect target

Behaviour:
- Reset: clk_i edge with rst_ni=0. All outputs 0, FIFO empty, state IDLE, all registers 0.
- Bus: ready=1 always. Access happens when valid=1; writes need valid & write. Decode on addr[8:2].
- rdata is combinational from the current register values.
- error=1 on: an unmapped index; a locked write; a write to TARGET/COUNT while busy.
- Writes that raise error have no effect.
- Register map:
  - 0 CMD (W): bit0 start, bit1 abort, bit2 clear status.
  - 1 TARGET (RW).
  - 2 COUNT (RW, 4 bits).
  - 3 DATA (W): push wdata[INSTR_WIDTH-1:0] into the FIFO.
  - 4 STATUS (R): {fifo_level[7:4], ovf[3], timeout[2], bad_cfg[1], busy[0]}; also done sticky at bit 8.
  - 5 OVR (RW): bit0 override, [8+:LOG] source, [16+:LOG] target.
- FIFO:
  - Push when not full. A push when full drops the data and sets ovf.
  - A simultaneous push and pop on a full FIFO is accepted.
  - Level is 0..FIFO_DEPTH. Pointers wrap modulo depth.
- FSM states: IDLE, LOAD, WAIT_ACK, DONE, ERROR.
- IDLE: on start, validate TARGET<N_TARGETS and 1<=COUNT<=MAX_WORDS.
  - If valid: clear sent counter and done sticky, go to LOAD.
  - If invalid: set bad_cfg, go to ERROR.
- LOAD: when the FIFO is non-empty, pop a word. On the next edge drive instrut_value=word and load_ctrl[TARGET]=1, clear the timer, go to WAIT_ACK. Otherwise wait; no timeout applies in LOAD.
- WAIT_ACK: hold the strobe and data stable.
  - When load_ack_i[TARGET]=1, drop load_ctrl next cycle and increment sent.
  - If sent+1==COUNT go to DONE, else go to LOAD.
  - Minimum 3 cycles per word.
  - The timer increments each cycle without ack. At TIMEOUT, set timeout, drop the strobe, go to ERROR.
  - Acks on other bits are ignored.
- DONE: done_o=1 for one cycle, done sticky=1, go to IDLE. Leftover FIFO words remain.
- ERROR: load_ctrl=0. Exit to IDLE only on a CMD write with bit2 (clear status), which also clears ovf/timeout/bad_cfg.
- Abort (CMD bit1) in any state: next cycle state=IDLE, load_ctrl=0, FIFO flushed, sent=0. Abort takes priority over start in the same write.
- Start while busy is ignored, with no error.
- busy = state in {LOAD, WAIT_ACK, DONE}.
- The OVR outputs are registered; updates are visible the cycle after the write.
- Reset mid-load: load_ctrl drops on the reset edge and the FIFO is emptied.

Test Plan:
- Write OVR=0x0000_0501, read back → rdata=0x501; override_o=1, r_source_o=5, r_target_o=0.
- TARGET=3, COUNT=2, DATA 0xA1, 0xB2, CMD=1; ack each strobe after 1 cycle → load_ctrl=0x0008 with instrut_value 0xA1, then 0xB2; done_o pulse; STATUS bit8=1, busy=0.
- COUNT=3 with only 1 word pushed → sequencer stalls in LOAD after word 1. Push 2 more words later → completes with done_o.
- Push 5 words into the depth-4 FIFO → ovf=1, level=4. Then no ack for 255 cycles on a load → timeout=1, ERROR state, load_ctrl=0. CMD=4 → IDLE, status cleared.
- COUNT=0 or TARGET=16 then start → bad_cfg=1, no strobe. reglk_ctrl_i=0x01 with a TARGET write → error=1, value unchanged.
- Abort mid-WAIT_ACK → load_ctrl=0 next cycle, FIFO level=0. rst_ni=0 mid-load → all outputs 0.
